// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with one-entry skid buffer; optional IF_ALIGN_CHECK_EN misaligned-redirect fault
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DROP  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] drop_addr_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic [31:0] skid_q;
  logic [31:0] skid_pc_q;

  logic        redir;
  logic        misalign;
  logic        bad_redir;
  logic        fault_q;
  logic [31:0] target;
  logic        consume;
  logic        take_direct;

`ifdef IF_ALIGN_CHECK_EN
  // Once faulted, every later redirect is ignored until reset.
  assign redir    = i_redirect && !fault_q;
  assign misalign = (i_redirect_pc[1:0] != 2'b00);
  assign target   = i_redirect_pc;
  assign o_fault  = fault_q;

  // Sticky fault flag, set by the first misaligned redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fault_q <= 1'b0;
    end else if (redir && misalign) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign redir    = i_redirect;
  assign misalign = 1'b0;
  assign target   = i_redirect_pc & 32'hFFFF_FFFC;
  assign fault_q  = 1'b0;
  assign o_fault  = 1'b0;
`endif

  assign bad_redir   = redir && misalign;
  assign consume     = instr_valid_q && !i_stall;
  // An accepted word lands in o_instr when the slot is free or being freed.
  assign take_direct = !instr_valid_q || consume;

  assign o_instr       = instr_q;
  assign o_instr_valid = instr_valid_q;
  assign o_pc          = instr_pc_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and request outputs; DROP keeps presenting the abandoned address.
  always_comb begin
    state_d    = state_q;
    o_mem_req  = 1'b0;
    o_mem_addr = pc_q;
    case (state_q)
      IDLE: begin
        state_d = bad_redir ? FAULT : REQ;
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (redir) begin
          if (i_mem_ack) state_d = bad_redir ? FAULT : REQ;
          else           state_d = DROP;
        end else if (i_mem_ack && !take_direct) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redir)        state_d = bad_redir ? FAULT : REQ;
        else if (consume) state_d = REQ;
      end
      DROP: begin
        o_mem_req  = 1'b1;
        o_mem_addr = drop_addr_q;
        if (i_mem_ack) state_d = (fault_q || bad_redir) ? FAULT : REQ;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: PC, output instruction register and skid entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      drop_addr_q   <= 32'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      skid_q        <= 32'h0;
      skid_pc_q     <= 32'h0;
    end else if (redir) begin
      instr_valid_q <= 1'b0;
      pc_q          <= target;
      if (state_q == REQ && !i_mem_ack) drop_addr_q <= pc_q;
    end else begin
      case (state_q)
        REQ: begin
          if (i_mem_ack) begin
            pc_q <= pc_q + 32'd4;
            if (take_direct) begin
              instr_q       <= i_mem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
            end else begin
              skid_q    <= i_mem_rdata;
              skid_pc_q <= pc_q;
            end
          end else if (consume) begin
            instr_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (consume) begin
            instr_q    <= skid_q;
            instr_pc_q <= skid_pc_q;
          end
        end
        default: begin
          if (consume) instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        i_clk;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_pc;
  logic        o_fault;

  int total = 0;
  int bad = 0;
  int mem_lat = 0;
  bit mem_const = 1'b0;
  int mem_cnt = 0;

  instr_fetch dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_stall       (i_stall),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_pc          (o_pc),
    .o_fault       (o_fault)
  );

  // Clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Memory responder: acks after mem_lat wait cycles, drives at falling edge.
  initial begin
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;
    forever begin
      @(negedge i_clk);
      if (o_mem_req) begin
        if (mem_cnt >= mem_lat) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = mem_const ? 32'h3333_3333 : (32'hC000_0000 | o_mem_addr);
          mem_cnt     = 0;
        end else begin
          i_mem_ack = 1'b0;
          mem_cnt   = mem_cnt + 1;
        end
      end else begin
        i_mem_ack = 1'b0;
        mem_cnt   = 0;
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst         = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_stall       = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_stream;
    mem_lat   = 0;
    mem_const = 1'b1;
    do_reset();
    tick();
    total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL stream_first_req req=%b addr=%h want req=1 addr=00000000", o_mem_req, o_mem_addr);
    end
    total++;
    if (o_instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_not_yet_valid valid=%b want 0", o_instr_valid);
    end
    tick();
    total++;
    if (o_instr_valid !== 1'b1 || o_instr !== 32'h3333_3333 || o_pc !== 32'h0) begin
      bad++;
      $display("FAIL stream_first_word valid=%b instr=%h pc=%h want 1 33333333 00000000", o_instr_valid, o_instr, o_pc);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (o_instr_valid !== 1'b1 || o_pc !== 32'(4 * k)) begin
        bad++;
        $display("FAIL stream_pc_%0d valid=%b pc=%h want 1 %h", k, o_instr_valid, o_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (o_mem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_instr !== 32'h0 ||
        o_pc !== 32'h0 || o_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_state req=%b valid=%b instr=%h pc=%h fault=%b want 0 0 00000000 00000000 0",
               o_mem_req, o_instr_valid, o_instr, o_pc, o_fault);
    end
  endtask

  task automatic test_latency;
    logic [31:0] exp_addr;
    mem_lat   = 3;
    mem_const = 1'b0;
    do_reset();
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_addr = 32'(4 * (k / 4));
      total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL latency_addr_%0d req=%b addr=%h want 1 %h", k, o_mem_req, o_mem_addr, exp_addr);
      end
      total++;
      if (o_instr_valid !== ((k % 4) == 0)) begin
        bad++;
        $display("FAIL latency_valid_%0d valid=%b want %b", k, o_instr_valid, (k % 4) == 0);
      end
      if ((k % 4) == 0) begin
        total++;
        if (o_pc !== exp_addr - 32'd4 || o_instr !== (32'hC000_0000 | (exp_addr - 32'd4))) begin
          bad++;
          $display("FAIL latency_word_%0d pc=%h instr=%h want %h", k, o_pc, o_instr, exp_addr - 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall;
    mem_lat   = 0;
    mem_const = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    total++;
    if (o_pc !== 32'h4 || o_instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_pre pc=%h valid=%b want 00000004 1", o_pc, o_instr_valid);
    end
    i_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (o_pc !== 32'h4 || o_instr !== 32'hC000_0004 || o_instr_valid !== 1'b1 || o_mem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold_%0d pc=%h instr=%h valid=%b req=%b want 00000004 c0000004 1 0",
                 k, o_pc, o_instr, o_instr_valid, o_mem_req);
      end
    end
    i_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (o_instr_valid !== 1'b1 || o_pc !== 32'(8 + 4 * k) || o_instr !== (32'hC000_0000 | 32'(8 + 4 * k))) begin
        bad++;
        $display("FAIL stall_release_%0d valid=%b pc=%h instr=%h want pc %h", k, o_instr_valid, o_pc, o_instr,
                 32'(8 + 4 * k));
      end
    end
  endtask

  task automatic test_redirect_wait;
    mem_lat   = 3;
    mem_const = 1'b0;
    do_reset();
    tick();
    repeat (8) tick();
    total++;
    if (o_instr_valid !== 1'b1 || o_pc !== 32'h4 || o_mem_addr !== 32'h8) begin
      bad++;
      $display("FAIL rdw_pre valid=%b pc=%h addr=%h want 1 00000004 00000008", o_instr_valid, o_pc, o_mem_addr);
    end
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    i_redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h8 || o_instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL rdw_drop_%0d req=%b addr=%h valid=%b want 1 00000008 0", k, o_mem_req, o_mem_addr, o_instr_valid);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL rdw_newreq_%0d req=%b addr=%h valid=%b want 1 00000100 0", k, o_mem_req, o_mem_addr, o_instr_valid);
      end
      tick();
    end
    total++;
    if (o_instr_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== 32'hC000_0100) begin
      bad++;
      $display("FAIL rdw_target_word valid=%b pc=%h instr=%h want 1 00000100 c0000100", o_instr_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_redirect_ack;
    mem_lat   = 0;
    mem_const = 1'b0;
    do_reset();
    tick();
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h40;
    tick();
    i_redirect = 1'b0;
    total++;
    if (o_instr_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 32'h40) begin
      bad++;
      $display("FAIL rda_discard valid=%b req=%b addr=%h want 0 1 00000040", o_instr_valid, o_mem_req, o_mem_addr);
    end
    tick();
    total++;
    if (o_instr_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== 32'hC000_0040) begin
      bad++;
      $display("FAIL rda_target_word valid=%b pc=%h instr=%h want 1 00000040 c0000040", o_instr_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_align;
    mem_lat   = 0;
    mem_const = 1'b0;
    do_reset();
    tick();
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h102;
    tick();
    i_redirect = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    total++;
    if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL align_fault fault=%b req=%b valid=%b want 1 0 0", o_fault, o_mem_req, o_instr_valid);
    end
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL align_ignore_%0d fault=%b req=%b valid=%b want 1 0 0", k, o_fault, o_mem_req, o_instr_valid);
      end
    end
    i_redirect = 1'b0;
    do_reset();
    total++;
    if (o_fault !== 1'b0) begin
      bad++;
      $display("FAIL align_clear fault=%b want 0", o_fault);
    end
    tick();
    total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL align_restart req=%b addr=%h want 1 00000000", o_mem_req, o_mem_addr);
    end
`else
    total++;
    if (o_fault !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL align_mask fault=%b req=%b addr=%h want 0 1 00000100", o_fault, o_mem_req, o_mem_addr);
    end
    tick();
    total++;
    if (o_instr_valid !== 1'b1 || o_pc !== 32'h100) begin
      bad++;
      $display("FAIL align_mask_word valid=%b pc=%h want 1 00000100", o_instr_valid, o_pc);
    end
`endif
  endtask

  initial begin
    i_rst         = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_stall       = 1'b0;
    test_stream();
    test_reset();
    test_latency();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
